// File: rtl/stream_resp_checker_if.sv
// Stimulus-side bundle for the response checker: expected bytes pushed by the
// driver and observed DUT output beats.
interface stream_resp_checker_if #(
    parameter int DATA_W = 8
);
    logic              exp_valid;
    logic [DATA_W-1:0] exp_data;
    logic              obs_valid;
    logic [DATA_W-1:0] obs_data;

    modport master (
        output exp_valid,
        output exp_data,
        output obs_valid,
        output obs_data
    );

    modport slave (
        input exp_valid,
        input exp_data,
        input obs_valid,
        input obs_data
    );
endinterface

// File: rtl/stream_resp_checker.sv
// Scoreboard receiver: queues expected bytes, compares them against observed DUT
// beats and produces match/error counts plus a pass/fail verdict after a drain.
module stream_resp_checker #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    stream_resp_checker_if.slave     bus,
    input  logic                     start,
    input  logic                     end_test,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              match_count,
    output logic [15:0]              err_count,
    output logic [DATA_W-1:0]        first_err_exp,
    output logic [DATA_W-1:0]        first_err_obs,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     timeout,
    output logic                     done,
    output logic                     pass
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [1:0]        state_r,     state_n;
    logic [AW-1:0]     wr_ptr_r,    wr_ptr_n;
    logic [AW-1:0]     rd_ptr_r,    rd_ptr_n;
    logic [AW:0]       level_r,     level_n;
    logic [15:0]       match_r,     match_n;
    logic [15:0]       err_r,       err_n;
    logic [DATA_W-1:0] fe_exp_r,    fe_exp_n;
    logic [DATA_W-1:0] fe_obs_r,    fe_obs_n;
    logic              ovf_r,       ovf_n;
    logic              unf_r,       unf_n;
    logic              to_r,        to_n;
    logic              done_r,      done_n;
    logic              pass_r,      pass_n;
    logic              mm_seen_r,   mm_seen_n;
    logic [CW-1:0]     drain_cnt_r, drain_cnt_n;

    logic              cmp_en_s;
    logic              pop_s;
    logic              unf_ev_s;
    logic              push_req_s;
    logic              push_s;
    logic [DATA_W-1:0] head_s;

    assign head_s     = mem_r[rd_ptr_r];
    assign cmp_en_s   = !start && ((state_r == ST_RUN) || (state_r == ST_DRAIN));
    assign pop_s      = cmp_en_s && bus.obs_valid && (level_r != '0);
    assign unf_ev_s   = cmp_en_s && bus.obs_valid && (level_r == '0);
    assign push_req_s = !start && (state_r == ST_RUN) && bus.exp_valid;
    // A full FIFO still accepts a push when the same cycle pops its head.
    assign push_s     = push_req_s && ((level_r != FULL_LVL) || pop_s);

    // Next-state computation for the FSM, FIFO bookkeeping, counters and flags.
    always_comb begin
        state_n     = state_r;
        wr_ptr_n    = wr_ptr_r;
        rd_ptr_n    = rd_ptr_r;
        level_n     = level_r;
        match_n     = match_r;
        err_n       = err_r;
        fe_exp_n    = fe_exp_r;
        fe_obs_n    = fe_obs_r;
        ovf_n       = ovf_r;
        unf_n       = unf_r;
        to_n        = to_r;
        mm_seen_n   = mm_seen_r;
        drain_cnt_n = drain_cnt_r;

        if (start) begin
            state_n     = ST_RUN;
            wr_ptr_n    = '0;
            rd_ptr_n    = '0;
            level_n     = '0;
            match_n     = 16'd0;
            err_n       = 16'd0;
            fe_exp_n    = '0;
            fe_obs_n    = '0;
            ovf_n       = 1'b0;
            unf_n       = 1'b0;
            to_n        = 1'b0;
            mm_seen_n   = 1'b0;
            drain_cnt_n = '0;
        end else begin
            if (pop_s) begin
                rd_ptr_n = rd_ptr_r + AW'(1);
                if (head_s == bus.obs_data) begin
                    match_n = sat_inc(match_r);
                end else begin
                    err_n = sat_inc(err_r);
                    if (!mm_seen_r) begin
                        fe_exp_n  = head_s;
                        fe_obs_n  = bus.obs_data;
                        mm_seen_n = 1'b1;
                    end else begin
                        mm_seen_n = mm_seen_r;
                    end
                end
            end else if (unf_ev_s) begin
                unf_n = 1'b1;
                err_n = sat_inc(err_r);
            end else begin
                rd_ptr_n = rd_ptr_r;
            end

            if (push_s) begin
                wr_ptr_n = wr_ptr_r + AW'(1);
            end else if (push_req_s) begin
                ovf_n = 1'b1;
            end else begin
                wr_ptr_n = wr_ptr_r;
            end

            level_n = level_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};

            case (state_r)
                ST_IDLE: begin
                    state_n = ST_IDLE;
                end
                ST_RUN: begin
                    if (end_test) begin
                        state_n     = ST_DRAIN;
                        drain_cnt_n = '0;
                    end else begin
                        state_n = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (level_r == '0) begin
                        state_n = ST_DONE;
                    end else if (drain_cnt_r == TO_LAST) begin
                        to_n    = 1'b1;
                        state_n = ST_DONE;
                    end else begin
                        drain_cnt_n = drain_cnt_r + CW'(1);
                    end
                end
                ST_DONE: begin
                    state_n = ST_DONE;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        done_n = (state_n == ST_DONE);
        pass_n = done_n && (err_n == 16'd0) && !ovf_n && !unf_n && !to_n;
    end

    // State and output registers; reset returns to IDLE with every output zero.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r     <= ST_IDLE;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            match_r     <= 16'd0;
            err_r       <= 16'd0;
            fe_exp_r    <= '0;
            fe_obs_r    <= '0;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
            to_r        <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            mm_seen_r   <= 1'b0;
            drain_cnt_r <= '0;
        end else begin
            state_r     <= state_n;
            wr_ptr_r    <= wr_ptr_n;
            rd_ptr_r    <= rd_ptr_n;
            level_r     <= level_n;
            match_r     <= match_n;
            err_r       <= err_n;
            fe_exp_r    <= fe_exp_n;
            fe_obs_r    <= fe_obs_n;
            ovf_r       <= ovf_n;
            unf_r       <= unf_n;
            to_r        <= to_n;
            done_r      <= done_n;
            pass_r      <= pass_n;
            mm_seen_r   <= mm_seen_n;
            drain_cnt_r <= drain_cnt_n;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.exp_data;
        end
    end

    assign fifo_level    = level_r;
    assign match_count   = match_r;
    assign err_count     = err_r;
    assign first_err_exp = fe_exp_r;
    assign first_err_obs = fe_obs_r;
    assign overflow      = ovf_r;
    assign underflow     = unf_r;
    assign timeout       = to_r;
    assign done          = done_r;
    assign pass          = pass_r;
endmodule

// File: tb/tb_stream_resp_checker.sv
// Randomised and directed bench: a queue-based reference model predicts every
// output per cycle; a separate monitor pops the predictions and compares.
module tb_stream_resp_checker;
    localparam int DW      = 8;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 256;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          end_test;
    logic [4:0]    fifo_level;
    logic [15:0]   match_count;
    logic [15:0]   err_count;
    logic [DW-1:0] first_err_exp;
    logic [DW-1:0] first_err_obs;
    logic          overflow;
    logic          underflow;
    logic          timeout;
    logic          done;
    logic          pass;

    always #5 clk = ~clk;

    stream_resp_checker_if #(.DATA_W(DW)) bus ();

    stream_resp_checker #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .start         (start),
        .end_test      (end_test),
        .fifo_level    (fifo_level),
        .match_count   (match_count),
        .err_count     (err_count),
        .first_err_exp (first_err_exp),
        .first_err_obs (first_err_obs),
        .overflow      (overflow),
        .underflow     (underflow),
        .timeout       (timeout),
        .done          (done),
        .pass          (pass)
    );

    typedef struct {
        int          level;
        int          match;
        int          err;
        logic [7:0]  fe_exp;
        logic [7:0]  fe_obs;
        bit          ovf;
        bit          unf;
        bit          to;
        bit          dn;
        bit          ps;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;

    logic [7:0] mq[$];
    int         m_state, m_match, m_err, m_drain;
    bit         m_ovf, m_unf, m_to, m_seen;
    logic [7:0] m_fe_exp, m_fe_obs;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    function automatic void model_clear(int st);
        mq.delete();
        m_state  = st;
        m_match  = 0;
        m_err    = 0;
        m_drain  = 0;
        m_ovf    = 0;
        m_unf    = 0;
        m_to     = 0;
        m_seen   = 0;
        m_fe_exp = 8'h00;
        m_fe_obs = 8'h00;
    endfunction

    function automatic void model_step(bit st, bit ev, logic [7:0] ed, bit ov,
                                       logic [7:0] od, bit et);
        int         pre;
        bit         popped;
        logic [7:0] h;
        if (st) begin
            model_clear(M_RUN);
            return;
        end
        pre    = mq.size();
        popped = 0;
        if ((m_state == M_RUN || m_state == M_DRAIN) && ov) begin
            if (pre > 0) begin
                h      = mq.pop_front();
                popped = 1;
                if (h == od) begin
                    if (m_match < 65535) m_match++;
                end else begin
                    if (m_err < 65535) m_err++;
                    if (!m_seen) begin
                        m_seen   = 1;
                        m_fe_exp = h;
                        m_fe_obs = od;
                    end
                end
            end else begin
                m_unf = 1;
                if (m_err < 65535) m_err++;
            end
        end
        if (m_state == M_RUN && ev) begin
            if (pre < DEPTH || popped) mq.push_back(ed);
            else m_ovf = 1;
        end
        if (m_state == M_RUN && et) begin
            m_state = M_DRAIN;
            m_drain = 0;
        end else if (m_state == M_DRAIN) begin
            m_drain++;
            if (pre == 0) begin
                m_state = M_DONE;
            end else if (m_drain >= TIMEOUT) begin
                m_to    = 1;
                m_state = M_DONE;
            end
        end
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.level  = mq.size();
        e.match  = m_match;
        e.err    = m_err;
        e.fe_exp = m_fe_exp;
        e.fe_obs = m_fe_obs;
        e.ovf    = m_ovf;
        e.unf    = m_unf;
        e.to     = m_to;
        e.dn     = (m_state == M_DONE);
        e.ps     = e.dn && (m_err == 0) && !m_ovf && !m_unf && !m_to;
        return e;
    endfunction

    task automatic drive_inputs(bit st, bit ev, logic [7:0] ed, bit ov, logic [7:0] od, bit et);
        start         = st;
        bus.exp_valid = ev;
        bus.exp_data  = ed;
        bus.obs_valid = ov;
        bus.obs_data  = od;
        end_test      = et;
    endtask

    task automatic step(bit st, bit ev, logic [7:0] ed, bit ov, logic [7:0] od, bit et);
        @(negedge clk);
        rst_n = 1'b0;
        drive_inputs(st, ev, ed, ov, od, et);
        model_step(st, ev, ed, ov, od, et);
        sb_q.push_back(snapshot());
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 8'h00, 0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive_inputs(0, 0, 8'h00, 0, 8'h00, 0);
        #1;
        chk("async_rst_level", fifo_level, 0);
        chk("async_rst_match", match_count, 0);
        chk("async_rst_err", err_count, 0);
        chk("async_rst_fe_exp", first_err_exp, 0);
        chk("async_rst_fe_obs", first_err_obs, 0);
        chk("async_rst_flags", {overflow, underflow, timeout}, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_pass", pass, 0);
        model_clear(M_IDLE);
        sb_q.push_back(snapshot());
    endtask

    // Monitor: one prediction per clock edge, compared shortly after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("fifo_level", fifo_level, e.level);
                chk("match_count", match_count, e.match);
                chk("err_count", err_count, e.err);
                chk("first_err_exp", first_err_exp, e.fe_exp);
                chk("first_err_obs", first_err_obs, e.fe_obs);
                chk("overflow", overflow, e.ovf);
                chk("underflow", underflow, e.unf);
                chk("timeout", timeout, e.to);
                chk("done", done, e.dn);
                chk("pass", pass, e.ps);
            end
        end
    end

    initial begin
        logic [7:0] od;
        bit         st, et, ev, ov;
        rst_n = 1'b1;
        drive_inputs(0, 0, 8'h00, 0, 8'h00, 0);

        // Clean two-byte run.
        do_reset();
        idle(2);
        step(1, 0, 8'h00, 0, 8'h00, 0);
        step(0, 1, 8'hA5, 0, 8'h00, 0);
        step(0, 1, 8'h5A, 0, 8'h00, 0);
        idle(1);
        step(0, 0, 8'h00, 1, 8'hA5, 0);
        step(0, 0, 8'h00, 1, 8'h5A, 0);
        step(0, 0, 8'h00, 0, 8'h00, 1);
        idle(3);

        // First mismatch latched; a later one leaves it alone.
        step(1, 0, 8'h00, 0, 8'h00, 0);
        step(0, 1, 8'hA5, 0, 8'h00, 0);
        step(0, 1, 8'h5A, 0, 8'h00, 0);
        step(0, 0, 8'h00, 1, 8'hA5, 0);
        step(0, 0, 8'h00, 1, 8'h5B, 0);
        step(0, 1, 8'h00, 0, 8'h00, 0);
        step(0, 0, 8'h00, 1, 8'hFF, 0);
        step(0, 0, 8'h00, 0, 8'h00, 1);
        idle(3);

        // Overflow, then the same fill with a pop on the 17th push.
        step(1, 0, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 17; i++) step(0, 1, 8'(i), 0, 8'h00, 0);
        idle(1);
        step(1, 0, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0, 8'h00, 0);
        step(0, 1, 8'h10, 1, 8'h00, 0);
        idle(1);

        // Underflow on empty FIFO, plus push and compare together while empty.
        step(1, 0, 8'h00, 0, 8'h00, 0);
        step(0, 0, 8'h00, 1, 8'h3C, 0);
        step(0, 1, 8'h44, 1, 8'h44, 0);
        idle(1);

        // Drain timeout with two entries left.
        step(1, 0, 8'h00, 0, 8'h00, 0);
        step(0, 1, 8'h10, 0, 8'h00, 0);
        step(0, 1, 8'h11, 0, 8'h00, 0);
        step(0, 1, 8'h12, 0, 8'h00, 0);
        step(0, 0, 8'h00, 1, 8'h10, 0);
        step(0, 0, 8'h00, 0, 8'h00, 1);
        idle(TIMEOUT + 4);

        // Mid-run async reset at level 5 / match 4, then a clean one-byte run.
        step(1, 0, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 8'(8'h30 + i), 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 8'(8'h30 + i), 0);
        do_reset();
        step(1, 0, 8'h00, 0, 8'h00, 0);
        step(0, 1, 8'h7E, 0, 8'h00, 0);
        step(0, 0, 8'h00, 1, 8'h7E, 0);
        step(0, 0, 8'h00, 0, 8'h00, 1);
        idle(3);

        // Randomised traffic, including stray start/end_test pulses.
        for (int i = 0; i < 600; i++) begin
            st = ($urandom_range(0, 99) < 2);
            et = ($urandom_range(0, 99) < 3);
            ev = ($urandom_range(0, 99) < 55);
            ov = ($urandom_range(0, 99) < 50);
            od = 8'($urandom_range(0, 255));
            if (mq.size() > 0 && $urandom_range(0, 2) != 0) od = mq[0];
            step(st, ev, 8'($urandom_range(0, 255)), ov, od, et);
        end

        // Error counter saturation through repeated mismatches.
        step(1, 0, 8'h00, 0, 8'h00, 0);
        step(0, 1, 8'h11, 0, 8'h00, 0);
        for (int i = 0; i < 65540; i++) step(0, 1, 8'h11, 1, 8'hEE, 0);
        step(0, 0, 8'h00, 0, 8'h00, 1);
        idle(3);

        // Let the monitor consume the remaining predictions, with a bound.
        for (int i = 0; i < 8 && sb_q.size() > 0; i++) @(posedge clk);
        #3;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_resp_checker.md
# stream_resp_checker

Self-checking response receiver for the 8-bit DUT data path: the consumer end of the stimulus stream. The stimulus side pushes each expected output byte into an internal FIFO as it drives the DUT input. The checker pops and compares one entry per observed DUT output beat. It reports match/mismatch counts, captures the first failing pair, and gives a single pass/fail verdict after an end-of-test drain. It sits beside the DUT instance in the top-level bench and replaces free-running `$monitor` printing with a cycle-accurate verdict.

## Interface
Parameters:
- DATA_W, 8, width of expected/observed data
- DEPTH, 16, expected-FIFO entries; power of 2, ≥2
- TIMEOUT, 256, max drain cycles after end_test before timeout is flagged; ≥1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-high (reset rst_n, asynchronous, active-high; clock clk)
- start  in  1  one-cycle pulse: clear all counters/flags/FIFO, enter RUN
- exp_valid  in  1  push exp_data into FIFO this cycle
- exp_data  in  DATA_W  expected DUT output byte
- obs_valid  in  1  DUT output beat present this cycle
- obs_data  in  DATA_W  DUT data_out sample
- end_test  in  1  one-cycle pulse: no more pushes; begin drain
- fifo_level  out  $clog2(DEPTH)+1  entries currently queued
- match_count  out  16  compares that matched, saturating
- err_count  out  16  mismatches plus underflows, saturating
- first_err_exp  out  DATA_W  expected value of first mismatch
- first_err_obs  out  DATA_W  observed value of first mismatch
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: obs_valid while empty
- timeout  out  1  sticky: drain exceeded TIMEOUT
- done  out  1  high in DONE state
- pass  out  1  valid when done; 1 iff err_count==0, !overflow, !underflow, !timeout

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset enters IDLE.
- IDLE: exp_valid/obs_valid ignored. start moves to RUN.
- RUN: pushes and compares are active. end_test moves to DRAIN.
- DRAIN: pushes are ignored; compares continue. Move to DONE when fifo_level==0. Also move to DONE after TIMEOUT cycles in DRAIN with the FIFO non-empty, setting timeout.
- DONE: pushes and compares are ignored. start clears everything and re-enters RUN. start in any state does the same. start has priority over end_test in the same cycle.
- Compare: obs_valid with FIFO non-empty pops the head.
  - head==obs_data: match_count+1.
  - Otherwise: err_count+1. On the first such event since start, latch head into first_err_exp and obs_data into first_err_obs.
- obs_valid with FIFO empty: underflow=1, err_count+1, nothing popped. first_err_* is not updated.
- Push while full:
  - Same-cycle pop present: pop happens first and the push is accepted.
  - No pop: data dropped, overflow=1.
- Push and compare while empty in the same cycle: no bypass. The pushed entry is stored and the compare is an underflow.
- Counters saturate at 16'hFFFF and do not wrap.
- FIFO pointers wrap modulo DEPTH. fifo_level counts 0..DEPTH.

## Timing
- Reset values of all outputs: 0. This includes fifo_level, counters, first_err_*, flags, done and pass.
- All outputs are registered. Effects of an input in cycle N are visible after the clk edge ending cycle N.
- Push-to-compare: an entry pushed in cycle N is comparable from cycle N+1.
- start in cycle N: cycle N+1 shows state RUN, all counters/flags 0, fifo_level 0. Inputs in cycle N other than start are ignored.
- end_test in cycle N:
  - DRAIN begins in cycle N+1.
  - If the FIFO is empty at N+1, done=1 and pass are valid at N+2.
  - The drain cycle counter starts at 0 in cycle N+1. timeout is set on the cycle the counter reaches TIMEOUT with level>0. done rises in the same cycle.
- Asynchronous reset mid-operation: immediate return to IDLE, FIFO emptied, all outputs 0. No verdict is produced.

## Test plan
- Reset, start, push A5,5A. Two cycles later obs A5,5A. Then end_test → match_count=2, err_count=0, done=1, pass=1.
- Push A5,5A; obs A5,5B → err_count=1, match_count=1, first_err_exp=5A, first_err_obs=5B, pass=0. A later second mismatch 00 vs FF leaves first_err_* unchanged.
- Push 17 bytes back-to-back with DEPTH=16 and no obs → overflow=1, fifo_level=16. Repeat with obs_valid on the 17th push cycle → no overflow, fifo_level=16.
- obs_valid with empty FIFO (obs_data=3C) → underflow=1, err_count=1, fifo_level stays 0.
- Push 3 bytes, obs 1, end_test, then no obs for 256 cycles → timeout=1 at drain cycle 256, done=1, pass=0, fifo_level=2.
- Mid-RUN with fifo_level=5 and match_count=4: rst_n asserted asynchronously → all outputs 0 without waiting for a clk edge. A following start then a clean 1-byte run → pass=1. Separately, force err_count to 16'hFFFF via repeated mismatches → it holds at FFFF.
